// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: one word-aligned bus transaction per request, byte-lane steering, load extension.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned H/W accesses return err 1 instead of being masked).
module lsu_mem_stage #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_is_store_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [4:0]      req_rd_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic [4:0]      rsp_rd_o,
  output logic [1:0]      rsp_err_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [3:0]      mem_wstrb_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_e;

  localparam logic [1:0] ERR_OK = 2'd0, ERR_MIS = 2'd1, ERR_TMO = 2'd2, ERR_ILL = 2'd3;

  state_e            state_q;
  logic              req_ready_q, rsp_valid_q, mem_req_q, mem_we_q, is_store_q;
  logic [XLEN-1:0]   rsp_rdata_q, mem_addr_q, mem_wdata_q;
  logic [4:0]        rsp_rd_q;
  logic [1:0]        rsp_err_q, lo_q;
  logic [2:0]        f3_q;
  logic [3:0]        mem_wstrb_q;
  logic [31:0]       cnt_q;

  // Accept-time decode of the incoming request
  logic              illegal, misalign;
  logic [1:0]        lo_d, err_d;
  logic [3:0]        wstrb_d;
  logic [XLEN-1:0]   wdata_d;

  always_comb begin
    illegal  = req_is_store_i ? (req_funct3_i > 3'b010)
                              : (req_funct3_i == 3'b011 || req_funct3_i[2:1] == 2'b11);
    misalign = (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
               (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00);
    lo_d     = req_addr_i[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    err_d    = illegal ? ERR_ILL : (misalign ? ERR_MIS : ERR_OK);
`else
    err_d    = illegal ? ERR_ILL : ERR_OK;
    if (req_funct3_i[1:0] == 2'b01) lo_d[0] = 1'b0;
    if (req_funct3_i[1:0] == 2'b10) lo_d    = 2'b00;
`endif
    wstrb_d  = 4'b0000;
    wdata_d  = req_wdata_i;
    if (req_is_store_i) begin
      case (req_funct3_i[1:0])
        2'b00:   begin wstrb_d = 4'b0001 << lo_d; wdata_d = {4{req_wdata_i[7:0]}};  end
        2'b01:   begin wstrb_d = 4'b0011 << lo_d; wdata_d = {2{req_wdata_i[15:0]}}; end
        default: wstrb_d = 4'b1111;
      endcase
    end
  end

  // Load extraction from the returned word
  logic [XLEN-1:0] sh, ext;
  always_comb begin
    sh = mem_rdata_i >> {lo_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{24{sh[7]}},  sh[7:0]};
      3'b100:  ext = {24'd0,        sh[7:0]};
      3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
      3'b101:  ext = {16'd0,        sh[15:0]};
      default: ext = sh;
    endcase
  end

  logic tmo_hit;
  assign tmo_hit = (MEM_TIMEOUT != 0) && (cnt_q == 32'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_rd_q    <= '0;
      rsp_err_q   <= ERR_OK;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      is_store_q  <= 1'b0;
      f3_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid_i) begin
          req_ready_q <= 1'b0;
          rsp_rd_q    <= req_rd_i;
          is_store_q  <= req_is_store_i;
          f3_q        <= req_funct3_i;
          lo_q        <= lo_d;
          if (err_d != ERR_OK) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_d;
            rsp_rdata_q <= '0;
          end else begin
            state_q     <= S_REQ;
            mem_req_q   <= 1'b1;
            mem_we_q    <= req_is_store_i;
            mem_addr_q  <= {req_addr_i[XLEN-1:2], 2'b00};
            mem_wstrb_q <= wstrb_d;
            mem_wdata_q <= wdata_d;
            cnt_q       <= '0;
          end
        end
        S_REQ: begin
          // An ack in the final timeout cycle still completes normally
          if (mem_ack_i) begin
            state_q     <= S_RESP;
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ERR_OK;
            rsp_rdata_q <= is_store_q ? '0 : ext;
          end else if (tmo_hit) begin
            state_q     <= S_RESP;
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ERR_TMO;
            rsp_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_RESP: if (rsp_ready_i) begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_rd_o    = rsp_rd_q;
  assign rsp_err_o   = rsp_err_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wstrb_o = mem_wstrb_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit for the core's memory stage: accepts one decoded LOAD/STORE from execute, performs a single word-aligned data-bus transaction with byte-lane steering, and returns load data already sign- or zero-extended to 32 bits. It sits between execute (upstream) and writeback (downstream) and is the only master on the data-memory port. It handles one transaction at a time, with no internal queue.

## Interface
- `XLEN`, 32: data and address width; only 32 is supported.
- `MEM_TIMEOUT`, 255: maximum cycles in REQ without `mem_ack` before the transaction is aborted; 0 disables the timeout.
- Clock and reset: single clock; reset is synchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `req_valid`  in  1  execute presents a memory operation.
- `req_ready`  out  1  the LSU can accept an operation.
- `req_is_store`  in  1  1 = STORE (opcode 0100011), 0 = LOAD (0000011).
- `req_funct3`  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010).
- `req_addr`  in  XLEN  effective byte address.
- `req_wdata`  in  XLEN  store data, taken from the low bits.
- `req_rd`  in  5  destination register, passed through unchanged.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  writeback accepts the response.
- `rsp_rdata`  out  XLEN  extended load data; 0 for stores and for errors.
- `rsp_rd`  out  5  captured `req_rd`.
- `rsp_err`  out  2  error code: 0 ok, 1 misaligned, 2 timeout, 3 illegal funct3.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  XLEN  word address, with `req_addr[1:0]` forced to 00.
- `mem_wstrb`  out  4  byte strobes.
- `mem_wdata`  out  XLEN  lane-replicated store data.
- `mem_ack`  in  1  bus completion; sampled only while `mem_req` = 1.
- `mem_rdata`  in  XLEN  read word; valid in the cycle `mem_ack` = 1.

## Operation
- FSM states:
  - IDLE: `req_ready` = 1. A handshake moves to REQ, or to RESP when an error is detected at accept.
  - REQ: `mem_req` = 1. `mem_ack` moves to RESP; the timeout also moves to RESP.
  - RESP: `rsp_valid` = 1. `rsp_ready` returns the FSM to IDLE.
- Request fields are registered at accept. All `mem_*` and `rsp_*` outputs are driven from registers.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: any value other than 000/001/010.
  - Result: err 3, no bus cycle.
- Store steering:
  - B: `mem_wdata` = {4{wdata[7:0]}}, `mem_wstrb` = 0001 << addr[1:0].
  - H: `mem_wdata` = {2{wdata[15:0]}}, `mem_wstrb` = 0011 << addr[1:0].
  - W: `mem_wdata` = wdata, `mem_wstrb` = 1111.
- Loads drive `mem_we` = 0 and `mem_wstrb` = 0000.
- Load extraction: shift `mem_rdata` right by 8 × addr[1:0], then:
  - B: sign-extend bit 7.
  - BU: zero-extend bits [7:0].
  - H: sign-extend bit 15.
  - HU: zero-extend bits [15:0].
  - W: pass through.
- Timeout: a counter clears on entering REQ and increments each REQ cycle without ack. When it reaches `MEM_TIMEOUT`, `mem_req` drops, the response is err 2, and `rsp_rdata` = 0.
- Simultaneous ack and timeout: ack wins and the response is ok.

## Timing
- Reset values, with `rst_n` low at an edge:
  - State is IDLE and `req_ready` = 1.
  - `mem_req`, `mem_we`, `mem_wstrb`, `mem_addr`, `mem_wdata` are all 0.
  - `rsp_valid`, `rsp_rdata`, `rsp_rd`, `rsp_err` are all 0.
- Accept at edge N:
  - `mem_req` is high from cycle N+1.
  - The earliest ack is in cycle N+1.
  - `rsp_valid` then rises in cycle N+2, giving a 2-cycle minimum latency.
- Error at accept: `rsp_valid` in cycle N+1, and `mem_req` never asserts.
- `mem_*` outputs hold stable from `mem_req` rise until the ack cycle. `mem_req` drops the cycle after ack.
- `rsp_*` outputs hold stable while `rsp_valid` && !`rsp_ready`.
- Throughput: `req_ready` returns in the cycle after the response handshake. There is no accept in the same cycle as the response.
- Reset mid-operation: the transaction is discarded with no response, and `mem_req` is 0 after the reset edge. The bus must tolerate an abandoned request.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses are H/HU/SH with addr[0] = 1, or W/SW with addr[1:0] ≠ 00.
  - They return err 1 in cycle N+1 with no bus cycle.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Misaligned low address bits are masked to natural alignment: H clears bit 0, W clears bits [1:0].
  - The access proceeds normally.
  - Error code 1 is never produced.

## Test plan
- LB at 0x1003, `mem_rdata` = 0x80FF_FF12, ack in 1st REQ cycle → `mem_addr` = 0x1000, `rsp_rdata` = 0xFFFF_FF80, `rsp_valid` in cycle N+2.
- LHU at 0x2002, `mem_rdata` = 0xBEEF_0001 → `rsp_rdata` = 0x0000_BEEF, `rsp_err` = 0.
- SB at 0x3001, `req_wdata` = 0x1234_56AB → `mem_we` = 1, `mem_wstrb` = 0010, `mem_wdata` = 0xABAB_ABAB, `rsp_rdata` = 0.
- LW at 0x4002:
  - With `LSU_MISALIGN_TRAP_EN`: err 1 in cycle N+1, `mem_req` stays 0.
  - Without the macro: `mem_addr` = 0x4000, ok response.
- `MEM_TIMEOUT` = 4 and `mem_ack` held low → `mem_req` high for exactly 4 cycles, then err 2, `rsp_rdata` = 0. A later ack is ignored.
- Response with `rsp_ready` low for 3 cycles → `rsp_*` stable and `req_ready` = 0. `rst_n` low during REQ → IDLE, `mem_req` = 0, no `rsp_valid`.
